// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and constants for the memory port arbiter and its watchdog.
//   MEM_ADDR_W / MEM_DATA_W / MEM_BE_W : bus field widths used by mem_req_t
//   arb_state_e                        : bus sequencing states
//   owner_e                            : which requester owns the current access
//   mem_req_t                          : registered copy of one bus request
//   cnt_width()                        : counter width able to hold 0..n (min 1)
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_MA
    } owner_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_BE_W-1:0]   be;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    // A limit of 0 still needs a 1-bit counter so the ports stay legal.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog
// Counts enabled cycles since the last clear and flags the cycle in which
// the count of enabled cycles reaches the limit. A limit of 0 never expires.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   i_clear   : restart the count (takes priority over i_enable)
//   i_enable  : count this cycle
//   i_limit   : number of enabled cycles allowed
//   o_expired : high during the i_limit-th enabled cycle after a clear
module mem_watchdog #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_expired
);

    localparam logic [CNT_W-1:0] ONE = 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ONE;
        end
    end

    // r_count holds the number of enabled cycles already spent, so the
    // current cycle is the last allowed one when it equals limit-1.
    assign o_expired = i_enable && (i_limit != '0) && (r_count == i_limit - ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between instruction fetch (IF) and
// load/store (MA). One access is outstanding at a time; MA has priority but
// IF is forced through after MAX_DATA_STREAK consecutive MA grants made while
// IF was waiting. A watchdog ends a hung response phase with an error pulse.
// ADDR_W/DATA_W must match the package widths used by mem_req_t.
//   clk, rst                                    : clock, async active-low reset
//   i_if_req, i_if_addr                         : fetch request (held to completion)
//   o_if_rdata, o_instr_ready                   : fetch data / fetch not stalled
//   i_ma_req, i_ma_we, i_ma_addr, i_ma_be,
//   i_ma_wdata                                  : data request (held to completion)
//   o_ma_rdata, o_data_ready                    : load data / data not stalled
//   o_err                                       : completion caused by timeout
//   o_mem_req, o_mem_we, o_mem_addr, o_mem_be,
//   o_mem_wdata                                 : bus address phase
//   i_mem_gnt, i_mem_rvalid, i_mem_rdata        : bus accept / response
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W          = MEM_ADDR_W,
    parameter int DATA_W          = MEM_DATA_W,
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_instr_ready,
    input  logic                i_ma_req,
    input  logic                i_ma_we,
    input  logic [ADDR_W-1:0]   i_ma_addr,
    input  logic [DATA_W/8-1:0] i_ma_be,
    input  logic [DATA_W-1:0]   i_ma_wdata,
    output logic [DATA_W-1:0]   o_ma_rdata,
    output logic                o_data_ready,
    output logic                o_err,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic                i_mem_gnt,
    input  logic                i_mem_rvalid,
    input  logic [DATA_W-1:0]   i_mem_rdata
);

    localparam int                  STREAK_W   = cnt_width(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = 1;
    localparam int                  WD_W       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]     WD_LIMIT   = WD_W'(TIMEOUT_CYCLES);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    owner_e              r_owner;
    mem_req_t            r_req;
    logic [STREAK_W-1:0] r_streak;

    logic w_any_req;
    logic w_grant_ma;
    logic w_expired;
    logic w_complete;

    assign w_any_req  = i_if_req || i_ma_req;
    // MA wins unless fetch has already been passed over STREAK_MAX times.
    assign w_grant_ma = i_ma_req && (!i_if_req || (r_streak != STREAK_MAX));

    // Next state plus the per-state outputs. An rvalid outside RESP falls
    // through untouched, which is how stray or post-reset responses are dropped.
    always_comb begin
        w_next_state = r_state;
        o_mem_req    = 1'b0;
        w_complete   = 1'b0;
        o_err        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next_state = ADDR;
                end
            end
            ADDR: begin
                o_mem_req = 1'b1;
                if (i_mem_gnt) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (i_mem_rvalid || w_expired) begin
                    w_complete   = 1'b1;
                    o_err        = !i_mem_rvalid;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winning request in IDLE so the bus fields stay stable for
    // however long gnt is withheld, independent of the requester's inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner <= OWN_IF;
            r_req   <= '0;
        end else if ((r_state == IDLE) && w_any_req) begin
            if (w_grant_ma) begin
                r_owner     <= OWN_MA;
                r_req.we    <= i_ma_we;
                r_req.addr  <= i_ma_addr;
                r_req.be    <= i_ma_be;
                r_req.wdata <= i_ma_wdata;
            end else begin
                r_owner     <= OWN_IF;
                r_req.we    <= 1'b0;
                r_req.addr  <= i_if_addr;
                r_req.be    <= '1;
                r_req.wdata <= '0;
            end
        end
    end

    // Streak of MA grants that overtook a waiting fetch. Only IDLE cycles
    // make arbitration decisions, so the count is frozen during an access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (r_state == IDLE) begin
            if (!i_if_req) begin
                r_streak <= '0;
            end else if (w_grant_ma) begin
                if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + STREAK_ONE;
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

    mem_watchdog #(
        .CNT_W(WD_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  ((r_state == ADDR) && i_mem_gnt),
        .i_enable (r_state == RESP),
        .i_limit  (WD_LIMIT),
        .o_expired(w_expired)
    );

    assign o_mem_we    = r_req.we;
    assign o_mem_addr  = r_req.addr;
    assign o_mem_be    = r_req.be;
    assign o_mem_wdata = r_req.wdata;

    assign o_if_rdata  = i_mem_rdata;
    assign o_ma_rdata  = i_mem_rdata;

    assign o_instr_ready = !i_if_req || (w_complete && (r_owner == OWN_IF));
    assign o_data_ready  = !i_ma_req || (w_complete && (r_owner == OWN_MA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives directed scenarios and randomized traffic into mem_port_arbiter and
// compares every cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic [31:0] o_if_rdata;
    logic        o_instr_ready;
    logic        i_ma_req = 1'b0;
    logic        i_ma_we = 1'b0;
    logic [31:0] i_ma_addr = '0;
    logic [3:0]  i_ma_be = '0;
    logic [31:0] i_ma_wdata = '0;
    logic [31:0] o_ma_rdata;
    logic        o_data_ready;
    logic        o_err;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .MAX_DATA_STREAK(MAXS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_instr_ready(o_instr_ready),
        .i_ma_req(i_ma_req), .i_ma_we(i_ma_we), .i_ma_addr(i_ma_addr),
        .i_ma_be(i_ma_be), .i_ma_wdata(i_ma_wdata),
        .o_ma_rdata(o_ma_rdata), .o_data_ready(o_data_ready),
        .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model of the port: is an access accepted, has its address phase been
    // taken, how many response cycles have elapsed, and what was sent.
    bit          mBusy = 0;
    bit          mGranted = 0;
    int          mRespCycles = 0;
    bit          mOwnerMa = 0;
    bit          mTxValid = 0;
    bit          mWe = 0;
    logic [31:0] mAddr = '0;
    logic [3:0]  mBe = '0;
    logic [31:0] mWdata = '0;
    int          mStreak = 0;
    bit          ifDoneEvt = 0;
    bit          maDoneEvt = 0;

    logic [31:0] dutGrantAddr[$];
    bit          prevMemReq = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Sets requester and bus inputs just after a rising edge.
    task automatic applyStimulus(input bit ifReq, input bit maReq, input bit gnt,
                                 input bit rvalid, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        i_if_req     = ifReq;
        i_ma_req     = maReq;
        i_mem_gnt    = gnt;
        i_mem_rvalid = rvalid;
        i_mem_rdata  = rdata;
    endtask

    task automatic waitSample;
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model, then model advance.
    always @(negedge clk) begin
        bit inResp;
        bit timeoutNow;
        bit completes;
        bit ifDone;
        bit maDone;
        bit expMemReq;
        bit maWins;
        if (!rst) begin
            mBusy = 0; mGranted = 0; mRespCycles = 0; mOwnerMa = 0; mTxValid = 0;
            mWe = 0; mAddr = '0; mBe = '0; mWdata = '0; mStreak = 0;
        end
        inResp     = rst && mBusy && mGranted;
        timeoutNow = inResp && (TO != 0) && (mRespCycles + 1 == TO);
        completes  = inResp && (i_mem_rvalid || timeoutNow);
        ifDone     = completes && !mOwnerMa;
        maDone     = completes && mOwnerMa;
        expMemReq  = rst && mBusy && !mGranted;

        checkOutput("mem_req", 32'(o_mem_req), 32'(expMemReq));
        checkOutput("mem_we", 32'(o_mem_we), 32'(mWe));
        checkOutput("mem_addr", o_mem_addr, mAddr);
        checkOutput("mem_be", 32'(o_mem_be), 32'(mBe));
        if (!mTxValid || mWe) checkOutput("mem_wdata", o_mem_wdata, mWdata);
        checkOutput("err", 32'(o_err), 32'(completes && !i_mem_rvalid));
        checkOutput("instr_ready", 32'(o_instr_ready), 32'(!i_if_req || ifDone));
        checkOutput("data_ready", 32'(o_data_ready), 32'(!i_ma_req || maDone));
        if (ifDone && i_mem_rvalid) checkOutput("if_rdata", o_if_rdata, i_mem_rdata);
        if (maDone && i_mem_rvalid) checkOutput("ma_rdata", o_ma_rdata, i_mem_rdata);

        if (o_mem_req && !prevMemReq) dutGrantAddr.push_back(o_mem_addr);
        prevMemReq = o_mem_req;

        if (rst) begin
            if (!mBusy) begin
                if (i_if_req || i_ma_req) begin
                    maWins = i_ma_req && (!i_if_req || mStreak < MAXS);
                    if (i_if_req && maWins) mStreak = mStreak + 1;
                    else mStreak = 0;
                    mBusy = 1; mGranted = 0; mTxValid = 1; mOwnerMa = maWins;
                    if (maWins) begin
                        mWe = i_ma_we; mAddr = i_ma_addr; mBe = i_ma_be; mWdata = i_ma_wdata;
                    end else begin
                        mWe = 0; mAddr = i_if_addr; mBe = 4'hF; mWdata = '0;
                    end
                end else begin
                    mStreak = 0;
                end
            end else if (!mGranted) begin
                if (i_mem_gnt) begin
                    mGranted = 1;
                    mRespCycles = 0;
                end
            end else if (completes) begin
                mBusy = 0;
            end else begin
                mRespCycles++;
            end
        end
        ifDoneEvt = ifDone;
        maDoneEvt = maDone;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] expOrder [10];
        bit ifActive;
        bit maActive;
        int gntPct [4];
        int rvPct [4];
        gntPct = '{100, 60, 50, 30};
        rvPct  = '{100, 50, 10, 5};
        expOrder = '{32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000,
                     32'h2000, 32'h2000, 32'h2000, 32'h2000, 32'h1000};

        // Reset values and ready following !req while held in reset.
        #2;
        checkOutput("rst_mem_req", 32'(o_mem_req), 32'h0);
        checkOutput("rst_mem_addr", o_mem_addr, 32'h0);
        checkOutput("rst_err", 32'(o_err), 32'h0);
        checkOutput("rst_iready_noreq", 32'(o_instr_ready), 32'h1);
        i_if_req = 1'b1;
        #1;
        checkOutput("rst_iready_req", 32'(o_instr_ready), 32'h0);
        i_if_req = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        waitSample;

        $display("[TB] fetch-only access");
        i_if_addr = 32'h100;
        applyStimulus(1, 0, 0, 0, 0); waitSample;
        checkOutput("t1_c0_memreq", 32'(o_mem_req), 32'h0);
        checkOutput("t1_c0_iready", 32'(o_instr_ready), 32'h0);
        applyStimulus(1, 0, 1, 0, 0); waitSample;
        checkOutput("t1_c1_memreq", 32'(o_mem_req), 32'h1);
        checkOutput("t1_c1_addr", o_mem_addr, 32'h100);
        checkOutput("t1_c1_be", 32'(o_mem_be), 32'hF);
        checkOutput("t1_c1_dready", 32'(o_data_ready), 32'h1);
        applyStimulus(1, 0, 0, 0, 0); waitSample;
        checkOutput("t1_c2_memreq", 32'(o_mem_req), 32'h0);
        checkOutput("t1_c2_iready", 32'(o_instr_ready), 32'h0);
        applyStimulus(1, 0, 0, 1, 32'hDEADBEEF); waitSample;
        checkOutput("t1_c3_iready", 32'(o_instr_ready), 32'h1);
        checkOutput("t1_c3_rdata", o_if_rdata, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0); waitSample;

        $display("[TB] simultaneous fetch and store, zero-wait bus");
        i_if_addr = 32'h104; i_ma_we = 1'b1; i_ma_addr = 32'h200;
        i_ma_be = 4'b0011; i_ma_wdata = 32'h1234;
        applyStimulus(1, 1, 1, 1, 0); waitSample;
        applyStimulus(1, 1, 1, 1, 0); waitSample;
        checkOutput("t2_c1_memreq", 32'(o_mem_req), 32'h1);
        checkOutput("t2_c1_we", 32'(o_mem_we), 32'h1);
        checkOutput("t2_c1_be", 32'(o_mem_be), 32'h3);
        checkOutput("t2_c1_addr", o_mem_addr, 32'h200);
        checkOutput("t2_c1_wdata", o_mem_wdata, 32'h1234);
        applyStimulus(1, 1, 1, 1, 0); waitSample;
        checkOutput("t2_c2_dready", 32'(o_data_ready), 32'h1);
        checkOutput("t2_c2_iready", 32'(o_instr_ready), 32'h0);
        applyStimulus(1, 0, 1, 1, 0); waitSample;
        checkOutput("t2_c3_memreq", 32'(o_mem_req), 32'h0);
        applyStimulus(1, 0, 1, 1, 0); waitSample;
        checkOutput("t2_c4_memreq", 32'(o_mem_req), 32'h1);
        checkOutput("t2_c4_addr", o_mem_addr, 32'h104);
        checkOutput("t2_c4_we", 32'(o_mem_we), 32'h0);
        checkOutput("t2_c4_iready", 32'(o_instr_ready), 32'h0);
        applyStimulus(1, 0, 1, 1, 0); waitSample;
        checkOutput("t2_c5_iready", 32'(o_instr_ready), 32'h1);
        applyStimulus(0, 0, 0, 0, 0); waitSample;

        $display("[TB] data streak limit");
        i_if_addr = 32'h1000; i_ma_we = 1'b0; i_ma_addr = 32'h2000;
        dutGrantAddr.delete();
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1, 1, 1, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0); waitSample;
        checkOutput("t3_grant_count", 32'(dutGrantAddr.size()), 32'd10);
        for (int g = 0; g < 10; g++) begin
            checkOutput($sformatf("t3_grant%0d", g),
                        (g < dutGrantAddr.size()) ? dutGrantAddr[g] : 32'hFFFF_FFFF, expOrder[g]);
        end

        $display("[TB] grant withheld");
        i_if_addr = 32'h300;
        applyStimulus(1, 0, 0, 0, 0); waitSample;
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(1, 0, 0, 0, 0); waitSample;
            checkOutput($sformatf("t4_c%0d_memreq", c), 32'(o_mem_req), 32'h1);
            checkOutput($sformatf("t4_c%0d_addr", c), o_mem_addr, 32'h300);
            checkOutput($sformatf("t4_c%0d_iready", c), 32'(o_instr_ready), 32'h0);
        end
        applyStimulus(1, 0, 1, 0, 0); waitSample;
        applyStimulus(1, 0, 0, 1, 32'h5A5A); waitSample;
        checkOutput("t4_done_iready", 32'(o_instr_ready), 32'h1);
        applyStimulus(0, 0, 0, 0, 0); waitSample;

        $display("[TB] watchdog expiry, then expiry coinciding with rvalid");
        i_ma_addr = 32'h400;
        for (int run = 0; run < 2; run++) begin
            applyStimulus(0, 1, 0, 0, 0); waitSample;
            applyStimulus(0, 1, 1, 0, 0); waitSample;
            for (int r = 1; r <= 8; r++) begin
                applyStimulus(0, 1, 0, (run == 1) && (r == 8), 32'hCAFE0001); waitSample;
                if (r < 8) begin
                    checkOutput($sformatf("t5_run%0d_r%0d_err", run, r), 32'(o_err), 32'h0);
                    checkOutput($sformatf("t5_run%0d_r%0d_dready", run, r), 32'(o_data_ready), 32'h0);
                end else begin
                    checkOutput($sformatf("t5_run%0d_expiry_err", run), 32'(o_err), (run == 0) ? 32'h1 : 32'h0);
                    checkOutput($sformatf("t5_run%0d_expiry_dready", run), 32'(o_data_ready), 32'h1);
                end
            end
            applyStimulus(0, 0, 0, 0, 0); waitSample;
            checkOutput($sformatf("t5_run%0d_after_err", run), 32'(o_err), 32'h0);
        end

        $display("[TB] reset during response phase");
        i_if_addr = 32'h500;
        applyStimulus(1, 0, 0, 0, 0); waitSample;
        applyStimulus(1, 0, 1, 0, 0); waitSample;
        applyStimulus(1, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6_rst_memreq", 32'(o_mem_req), 32'h0);
        checkOutput("t6_rst_addr", o_mem_addr, 32'h0);
        checkOutput("t6_rst_err", 32'(o_err), 32'h0);
        waitSample;
        applyStimulus(1, 0, 0, 0, 0);
        rst = 1'b1;
        waitSample;
        checkOutput("t6_c3_memreq", 32'(o_mem_req), 32'h0);
        applyStimulus(1, 0, 0, 1, 32'h77); waitSample;
        checkOutput("t6_late_rvalid_iready", 32'(o_instr_ready), 32'h0);
        checkOutput("t6_late_rvalid_err", 32'(o_err), 32'h0);
        checkOutput("t6_late_rvalid_memreq", 32'(o_mem_req), 32'h1);
        applyStimulus(1, 0, 1, 0, 0); waitSample;
        applyStimulus(1, 0, 0, 1, 32'h88); waitSample;
        checkOutput("t6_done_iready", 32'(o_instr_ready), 32'h1);
        applyStimulus(0, 0, 0, 0, 0); waitSample;

        $display("[TB] randomized traffic");
        ifActive = 0;
        maActive = 0;
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 800; n++) begin
                @(posedge clk);
                #1;
                if (ifActive && ifDoneEvt) ifActive = 0;
                if (maActive && maDoneEvt) maActive = 0;
                if (!ifActive && ($urandom_range(0, 99) < 50)) begin
                    ifActive  = 1;
                    i_if_addr = $urandom;
                end
                if (!maActive && ($urandom_range(0, 99) < 60)) begin
                    maActive   = 1;
                    i_ma_we    = 1'($urandom_range(0, 1));
                    i_ma_addr  = $urandom;
                    i_ma_be    = 4'($urandom_range(0, 15));
                    i_ma_wdata = $urandom;
                end
                i_if_req     = ifActive;
                i_ma_req     = maActive;
                i_mem_gnt    = ($urandom_range(0, 99) < gntPct[p]);
                i_mem_rvalid = ($urandom_range(0, 99) < rvPct[p]);
                i_mem_rdata  = $urandom;
                rst          = ($urandom_range(0, 499) != 0);
            end
        end
        applyStimulus(0, 0, 0, 0, 0);
        rst = 1'b1;
        waitSample;
        waitSample;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the core's single memory port between the instruction-fetch (IF) requester and the memory-access (MA, load/store) requester.
- Arbitrates between them with data-priority plus an anti-starvation streak limit.
- Sequences a req/gnt/rvalid bus handshake with one transaction outstanding.
- Produces the per-requester ready levels that the pipeline hazard logic consumes as structural-hazard inputs. A requester's ready is low while its access is pending.
- A watchdog completes a hung transaction with an error flag.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch is waiting.
- TIMEOUT_CYCLES, 255, response-wait limit; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- i_if_req  in  1  fetch request; held until completion.
- i_if_addr  in  ADDR_W  fetch address.
- o_if_rdata  out  DATA_W  fetch data; valid on the completion cycle.
- o_instr_ready  out  1  !i_if_req OR fetch completes this cycle.
- i_ma_req  in  1  data request; held until completion.
- i_ma_we  in  1  1 = store.
- i_ma_addr  in  ADDR_W  data address.
- i_ma_be  in  DATA_W/8  store byte enables.
- i_ma_wdata  in  DATA_W  store data.
- o_ma_rdata  out  DATA_W  load data; valid on the completion cycle.
- o_data_ready  out  1  !i_ma_req OR data access completes this cycle.
- o_err  out  1  one-cycle pulse together with a completion caused by timeout.
- o_mem_req  out  1  bus address-phase valid.
- o_mem_we  out  1  bus write.
- o_mem_addr  out  ADDR_W  bus address.
- o_mem_be  out  DATA_W/8  bus byte enables.
- o_mem_wdata  out  DATA_W  bus write data.
- i_mem_gnt  in  1  bus accepts the address phase.
- i_mem_rvalid  in  1  bus response; returned for both reads and writes.
- i_mem_rdata  in  DATA_W  bus read data.

Behaviour:
- FSM states: IDLE, ADDR, RESP. Registered owner: OWN_IF or OWN_MA.
- IDLE:
  - If any request is present, select the owner, register the address, we, be and wdata, then go to ADDR.
  - Fetch always uses be = all ones and we = 0.
- ADDR:
  - o_mem_req = 1; bus fields come from the registered copy.
  - On i_mem_gnt go to RESP; otherwise hold and keep bus fields stable.
- RESP:
  - o_mem_req = 0.
  - On i_mem_rvalid: complete (owner's ready = 1 this cycle), then go to IDLE.
  - If the watchdog count reaches TIMEOUT_CYCLES with no rvalid: complete, pulse o_err, go to IDLE.
  - An i_mem_rvalid arriving in any other state is ignored.
- Latency: request seen in cycle 0 → o_mem_req in cycle 1 → completion no earlier than cycle 2 (gnt in cycle 1, rvalid in cycle 2). Back-to-back accesses cost one IDLE cycle between them.
- Read data: o_if_rdata and o_ma_rdata are direct pass-throughs of i_mem_rdata. They are meaningful only on the owner's completion cycle; on a timeout completion they are don't-care.
- Arbitration in IDLE:
  - Only one requester: it wins.
  - Both requesting: MA wins unless streak == MAX_DATA_STREAK, in which case IF wins.
  - streak (width clog2(MAX_DATA_STREAK+1)) increments on each MA grant made while i_if_req = 1, saturating at the limit.
  - streak clears on any IF grant, and in any IDLE cycle with i_if_req = 0.
- Watchdog counter: clears on entry to RESP and increments each RESP cycle.
- Ready is combinational: o_X_ready = !i_X_req || (state == RESP && owner == X && (i_mem_rvalid || timeout)). The non-owner's ready stays low while its own request waits.
- A requester that drops its request mid-transaction is a protocol violation. The transaction still finishes on the bus and the response is discarded. Completion with no request present does not change ready, which is already 1.
- Simultaneous rvalid and timeout: treated as a normal completion, o_err = 0.
- Reset values (asynchronous, while rst = 0):
  - State = IDLE, owner = OWN_IF, streak = 0, watchdog = 0.
  - o_mem_req, o_mem_we, o_err = 0.
  - o_mem_addr, o_mem_be, o_mem_wdata = 0.
  - Ready outputs follow !req.
- Reset asserted mid-transaction: o_mem_req drops immediately, and any late rvalid after reset is ignored.

Decomposition:
- Shared core package holds:
  - typedef enum arb_state_e {IDLE, ADDR, RESP}.
  - typedef enum owner_e {OWN_IF, OWN_MA}.
  - Bus request struct mem_req_t {we, addr, be, wdata}, sized from package constants for address and data width.
- One natural sub-module: mem_watchdog (clear, enable, limit → expired). Everything else stays in one module.

Test Plan:
- IF only, addr 0x100; gnt in cycle 1; rvalid with rdata 0xDEADBEEF in cycle 3 → o_mem_req high only in cycle 1; o_instr_ready = 0 in cycles 0–2 and 1 in cycle 3 with o_if_rdata = 0xDEADBEEF; o_data_ready = 1 throughout.
- IF and MA both requesting from cycle 0, MA store to 0x200 with be 4'b0011 and wdata 0x1234; zero-wait bus → MA served first with o_mem_we = 1, be 0011, addr 0x200; IF address phase starts in the IDLE+1 cycle after MA completes.
- MA requesting continuously with IF also requesting, MAX_DATA_STREAK = 4 → grant order MA, MA, MA, MA, IF, MA…; streak returns to 0 after the IF grant.
- gnt withheld for 5 cycles → o_mem_req and o_mem_addr stay stable all 5 cycles, no completion occurs, and the owner's ready stays 0.
- TIMEOUT_CYCLES = 8, no rvalid → completion on the 8th RESP cycle with o_err = 1 for one cycle; the next request proceeds normally. A second run with rvalid and expiry in the same cycle → o_err = 0.
- rst driven low while in RESP → o_mem_req = 0 and state = IDLE immediately; an rvalid arriving 2 cycles later causes no ready pulse and no o_err.
